writeback_mux_reg: RTL and testbench

WRITEBACK_MUX_REG -- requirements
Module: writeback_mux_reg

---
 rtl/writeback_mux_reg.sv | 126 ++++++++++++
 tb/tb_writeback_mux_reg.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/writeback_mux_reg.sv
// Writeback mux and output register: one-cycle latency, valid/ready; a MUL result is written back as two beats (low half, then high half) when WB_MUL_HI_EN is defined.
// Ready is low while a beat cannot be retired, so nothing is dropped; without WB_MUL_HI_EN a MUL writes back only its low half.
module writeback_mux_reg #(
  parameter int WIDTH = 24
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   Hyrja0,
  input  logic [2*WIDTH-1:0] Hyrja1,
  input  logic [WIDTH-1:0]   Hyrja2,
  input  logic [2:0]         S,
  input  logic               In_valid,
  output logic               In_ready,
  output logic               Out_valid,
  input  logic               Out_ready,
  output logic [WIDTH-1:0]   Dalja,
  output logic               Dalja_hi,
  output logic [1:0]         Dalja_src,
  output logic               Gabim
);

  typedef enum logic [1:0] {EMPTY, ONE, MUL_HI} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] dat_nx;
  logic [1:0]       src_nx;
  logic             gabim_nx;
  logic             ready_en;
  logic             take;

`ifdef WB_MUL_HI_EN
  logic [WIDTH-1:0] hi_buf;
  logic [WIDTH-1:0] hi_buf_nx;
  logic             hi_nx;
`else
  logic unused_upper;
  assign unused_upper = ^Hyrja1[2*WIDTH-1:WIDTH];
  assign Dalja_hi     = 1'b0;
`endif

  assign Out_valid = (state != EMPTY);
  // ready_en keeps In_ready low until the first clock edge after reset release
  assign In_ready  = ready_en & ((state == EMPTY)
                              | ((state == ONE) & Out_ready)
                              | ((state == MUL_HI) & Out_ready & Dalja_hi));
  assign take      = In_valid & In_ready;

  always_comb begin
    state_nx  = state;
    dat_nx    = Dalja;
    src_nx    = Dalja_src;
    gabim_nx  = Gabim;
`ifdef WB_MUL_HI_EN
    hi_nx     = Dalja_hi;
    hi_buf_nx = hi_buf;
`endif
    if (take) begin
      state_nx = ONE;
      gabim_nx = 1'b0;
`ifdef WB_MUL_HI_EN
      hi_nx    = 1'b0;
`endif
      case (S)
        3'b100: begin
          dat_nx = Hyrja1[WIDTH-1:0];
          src_nx = 2'd1;
`ifdef WB_MUL_HI_EN
          state_nx  = MUL_HI;
          hi_buf_nx = Hyrja1[2*WIDTH-1:WIDTH];
`endif
        end
        3'b110: begin
          dat_nx = Hyrja2;
          src_nx = 2'd2;
        end
        3'b111: begin
          dat_nx   = '0;
          src_nx   = 2'd3;
          gabim_nx = 1'b1;
        end
        default: begin
          dat_nx = Hyrja0;
          src_nx = 2'd0;
        end
      endcase
    end else if (Out_valid && Out_ready) begin
`ifdef WB_MUL_HI_EN
      // Low MUL half retired: swap in the buffered high half, same source tag
      if ((state == MUL_HI) && !Dalja_hi) begin
        dat_nx = hi_buf;
        hi_nx  = 1'b1;
      end else begin
        state_nx = EMPTY;
      end
`else
      state_nx = EMPTY;
`endif
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= EMPTY;
      Dalja     <= '0;
      Dalja_src <= 2'd0;
      Gabim     <= 1'b0;
      ready_en  <= 1'b0;
`ifdef WB_MUL_HI_EN
      Dalja_hi  <= 1'b0;
      hi_buf    <= '0;
`endif
    end else begin
      state     <= state_nx;
      Dalja     <= dat_nx;
      Dalja_src <= src_nx;
      Gabim     <= gabim_nx;
      ready_en  <= 1'b1;
`ifdef WB_MUL_HI_EN
      Dalja_hi  <= hi_nx;
      hi_buf    <= hi_buf_nx;
`endif
    end
  end

endmodule

// File: tb/tb_writeback_mux_reg.sv
// Directed bench for writeback_mux_reg; expectations follow WB_MUL_HI_EN when it is defined.
module tb_writeback_mux_reg;

  logic        Clock;
  logic        Reset;
  logic [23:0] Hyrja0;
  logic [47:0] Hyrja1;
  logic [23:0] Hyrja2;
  logic [2:0]  S;
  logic        In_valid;
  logic        In_ready;
  logic        Out_valid;
  logic        Out_ready;
  logic [23:0] Dalja;
  logic        Dalja_hi;
  logic [1:0]  Dalja_src;
  logic        Gabim;

  int tests = 0;
  int fails = 0;

  writeback_mux_reg #(.WIDTH(24)) dut (
    .Clock(Clock), .Reset(Reset), .Hyrja0(Hyrja0), .Hyrja1(Hyrja1), .Hyrja2(Hyrja2),
    .S(S), .In_valid(In_valid), .In_ready(In_ready), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .Dalja(Dalja), .Dalja_hi(Dalja_hi), .Dalja_src(Dalja_src),
    .Gabim(Gabim)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; In_valid = 1'b0; Out_ready = 1'b1; S = 3'b000;
    Hyrja0 = '0; Hyrja1 = '0; Hyrja2 = '0;
    #2;
    tests++; if (Out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", Out_valid); end
    tests++; if (In_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", In_ready); end
    tests++; if (Dalja !== 24'h0) begin fails++; $display("FAIL rst_dat: got %h want 000000", Dalja); end
    tests++; if ({Dalja_hi, Dalja_src, Gabim} !== 4'b0) begin fails++; $display("FAIL rst_flags: got %b want 0000", {Dalja_hi, Dalja_src, Gabim}); end
    step();
    Reset = 1'b1;
    #1;
    tests++; if (In_ready !== 1'b0) begin fails++; $display("FAIL rel_ready_early: got %b want 0", In_ready); end
    step();
    tests++; if (In_ready !== 1'b1) begin fails++; $display("FAIL rel_ready: got %b want 1", In_ready); end
  endtask

  task automatic test_alu_back_to_back();
    Out_ready = 1'b1; In_valid = 1'b1; S = 3'b000; Hyrja0 = 24'h123456; Hyrja2 = 24'hEEEEEE;
    step();
    tests++; if (Out_valid !== 1'b1) begin fails++; $display("FAIL alu_valid: got %b want 1", Out_valid); end
    tests++; if (Dalja !== 24'h123456) begin fails++; $display("FAIL alu_dat: got %h want 123456", Dalja); end
    tests++; if (Dalja_src !== 2'd0) begin fails++; $display("FAIL alu_src: got %0d want 0", Dalja_src); end
    tests++; if (In_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", In_ready); end
    S = 3'b001; Hyrja0 = 24'h654321;
    step();
    tests++; if (Dalja !== 24'h654321) begin fails++; $display("FAIL b2b_dat1: got %h want 654321", Dalja); end
    S = 3'b101; Hyrja0 = 24'h0000AA;
    step();
    tests++; if (Dalja !== 24'h0000AA || Dalja_src !== 2'd0) begin fails++; $display("FAIL b2b_dat2: got %h/%0d want 0000aa/0", Dalja, Dalja_src); end
    In_valid = 1'b0; S = 3'b110; Hyrja2 = 24'h777777;
    step();
    tests++; if (Out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b want 0", Out_valid); end
  endtask

  task automatic test_stall_hyrja2();
    Out_ready = 1'b0; In_valid = 1'b1; S = 3'b110; Hyrja2 = 24'h00FF00; Hyrja0 = 24'h111111;
    step();
    Hyrja2 = 24'h123123;
    for (int i = 0; i < 5; i++) begin
      tests++; if (Out_valid !== 1'b1 || Dalja !== 24'h00FF00 || Dalja_src !== 2'd2 || In_ready !== 1'b0)
        begin fails++; $display("FAIL stall_%0d: got v=%b d=%h src=%0d rdy=%b want 1/00ff00/2/0", i, Out_valid, Dalja, Dalja_src, In_ready); end
      step();
    end
    In_valid = 1'b0; Out_ready = 1'b1;
    step();
    tests++; if (Out_valid !== 1'b0) begin fails++; $display("FAIL stall_drain: got %b want 0", Out_valid); end
  endtask

  task automatic test_illegal();
    Out_ready = 1'b1; In_valid = 1'b1; S = 3'b111; Hyrja0 = 24'hFFFFFF; Hyrja2 = 24'hFFFFFF;
    step();
    In_valid = 1'b0;
    tests++; if (Out_valid !== 1'b1 || Dalja !== 24'h0) begin fails++; $display("FAIL ill_dat: got v=%b d=%h want 1/000000", Out_valid, Dalja); end
    tests++; if (Gabim !== 1'b1 || Dalja_src !== 2'd3) begin fails++; $display("FAIL ill_flags: got gabim=%b src=%0d want 1/3", Gabim, Dalja_src); end
    step();
    tests++; if (Out_valid !== 1'b0) begin fails++; $display("FAIL ill_once: got %b want 0", Out_valid); end
  endtask

  task automatic test_mul();
    Out_ready = 1'b1; In_valid = 1'b1; S = 3'b100; Hyrja1 = 48'hABCDEF_012345;
    step();
    S = 3'b000; Hyrja0 = 24'h111111;
    tests++; if (Dalja !== 24'h012345 || Dalja_hi !== 1'b0 || Dalja_src !== 2'd1)
      begin fails++; $display("FAIL mul_lo: got %h hi=%b src=%0d want 012345/0/1", Dalja, Dalja_hi, Dalja_src); end
`ifdef WB_MUL_HI_EN
    tests++; if (In_ready !== 1'b0) begin fails++; $display("FAIL mul_lo_ready: got %b want 0", In_ready); end
    step();
    tests++; if (Dalja !== 24'hABCDEF || Dalja_hi !== 1'b1 || Dalja_src !== 2'd1)
      begin fails++; $display("FAIL mul_hi: got %h hi=%b src=%0d want abcdef/1/1", Dalja, Dalja_hi, Dalja_src); end
    tests++; if (In_ready !== 1'b1) begin fails++; $display("FAIL mul_hi_ready: got %b want 1", In_ready); end
`else
    tests++; if (In_ready !== 1'b1) begin fails++; $display("FAIL mul_single_ready: got %b want 1", In_ready); end
`endif
    step();
    In_valid = 1'b0;
    tests++; if (Out_valid !== 1'b1 || Dalja !== 24'h111111 || Dalja_hi !== 1'b0)
      begin fails++; $display("FAIL mul_next: got v=%b d=%h hi=%b want 1/111111/0", Out_valid, Dalja, Dalja_hi); end
    step();
    tests++; if (Out_valid !== 1'b0) begin fails++; $display("FAIL mul_drain: got %b want 0", Out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    Out_ready = 1'b0; In_valid = 1'b1; S = 3'b100; Hyrja1 = 48'h555555_AAAAAA;
    step();
    In_valid = 1'b0;
    tests++; if (Dalja !== 24'hAAAAAA) begin fails++; $display("FAIL rmid_lo: got %h want aaaaaa", Dalja); end
    #2 Reset = 1'b0;
    #1;
    tests++; if (Out_valid !== 1'b0 || Dalja !== 24'h0 || In_ready !== 1'b0)
      begin fails++; $display("FAIL rmid_async: got v=%b d=%h rdy=%b want 0/000000/0", Out_valid, Dalja, In_ready); end
    step();
    Reset = 1'b1; Out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (Out_valid !== 1'b0 || Dalja_hi !== 1'b0 || Dalja === 24'h555555)
        begin fails++; $display("FAIL rmid_post_%0d: got v=%b hi=%b d=%h want 0/0/not 555555", i, Out_valid, Dalja_hi, Dalja); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_stall_hyrja2();
    test_illegal();
    test_mul();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
